// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer port bundle: display read port, writer port and the BRAM port.
// master = requesters plus RAM side, slave = the arbiter.
interface fb_port_arbiter_if #(
   parameter int AW = 19,
   parameter int DW = 12
);
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_rdata;
   logic          disp_rvalid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;

   modport master (
      output disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
      input  disp_rdata, disp_rvalid, wr_ack, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
      output disp_rdata, disp_rvalid, wr_ack, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, writes fill idle cycles.
// Define FB_ARB_STATS_EN to build the rd_cnt/wr_cnt issue counters (tied to zero otherwise).
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no RAM access issued this cycle
// S_RD   | display read address on mem_addr
// S_WR   | write on mem_addr/mem_wdata, mem_we and wr_ack high
module fb_port_arbiter #(
   parameter int AW          = 19,
   parameter int DW          = 12,
   parameter int RD_LAT      = 1,
   parameter int MAX_WAIT    = 800,
   parameter int VBLANK_ONLY = 0
) (
   input  logic             pclk,
   input  logic             rstn,
   fb_port_arbiter_if.slave fb,
   input  logic             vblank,
   input  logic             clr_starve,
   output logic             wr_starve,
   output logic [15:0]      rd_cnt,
   output logic [15:0]      wr_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

   localparam logic [15:0] WAIT_TC = 16'(MAX_WAIT - 1);

   state_t          state;
   logic            wr_ok, rd_go, wr_go, waiting;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q, rdata_q;
   logic            we_q, ack_q;
   logic [15:0]     wait_cnt;
   logic [RD_LAT:0] vld;

   always_comb begin
      wr_ok   = (VBLANK_ONLY != 0) ? vblank : 1'b1;
      rd_go   = fb.disp_req;
      // no write right after a write, so the writer can drop wr_req after its ack
      wr_go   = !fb.disp_req && fb.wr_req && wr_ok && (state != S_WR);
      waiting = fb.wr_req && !wr_go;
   end

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         ack_q     <= 1'b0;
         wait_cnt  <= '0;
         wr_starve <= 1'b0;
      end else begin
         we_q  <= 1'b0;
         ack_q <= 1'b0;
         if (rd_go) begin
            state  <= S_RD;
            addr_q <= fb.disp_addr;
         end else if (wr_go) begin
            state   <= S_WR;
            addr_q  <= fb.wr_addr;
            wdata_q <= fb.wr_data;
            we_q    <= 1'b1;
            ack_q   <= 1'b1;
         end else begin
            state <= S_IDLE;
         end

         if (waiting && wait_cnt == WAIT_TC)
            wr_starve <= 1'b1;
         else if (clr_starve)
            wr_starve <= 1'b0;

         if (!waiting)
            wait_cnt <= '0;
         else if (wait_cnt != 16'hFFFF)
            wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // vld[0] marks an address launched this edge; rdata is captured RD_LAT edges later
   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         vld     <= '0;
         rdata_q <= '0;
      end else begin
         vld <= {vld[RD_LAT-1:0], rd_go};
         if (vld[RD_LAT-1])
            rdata_q <= fb.mem_rdata;
      end
   end

   assign fb.mem_addr    = addr_q;
   assign fb.mem_wdata   = wdata_q;
   assign fb.mem_we      = we_q;
   assign fb.wr_ack      = ack_q;
   assign fb.disp_rvalid = vld[RD_LAT];
   assign fb.disp_rdata  = rdata_q;

`ifdef FB_ARB_STATS_EN
   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_go) rd_cnt <= rd_cnt + 16'd1;
         if (wr_go) wr_cnt <= wr_cnt + 16'd1;
      end
   end
`else
   assign rd_cnt = 16'h0000;
   assign wr_cnt = 16'h0000;
`endif

endmodule
